// File: rtl/am_demodulate.sv
// AM envelope detector: register, full-wave rectify, boxcar average over 2^AVG_LOG2 samples.
// Optional DC removal with a leaky integrator when AM_DEMOD_DC_BLOCK_EN is defined.
module am_demodulate #(
  parameter int INPUT_WIDTH = 12,
  parameter int AVG_LOG2    = 6,
  parameter int DC_SHIFT    = 8
) (
  input  logic                          clk_in,
  input  logic                          RST,
  input  logic signed [INPUT_WIDTH-1:0] AM_wave,
  output logic signed [INPUT_WIDTH-1:0] wave_out,
  output logic                          wave_valid
);

  localparam int RW    = INPUT_WIDTH - 1;
  localparam int SUM_W = RW + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] LAST_IDX = AVG_LOG2'(DEPTH - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t state_q, state_d;

  logic signed [INPUT_WIDTH-1:0] am_q, am_d, am_neg;
  logic                          v1_q, v1_d;
  logic [RW-1:0]                 rect_q, rect_d;
  logic                          v2_q, v2_d;
  logic [SUM_W-1:0]              sum_q, sum_d;
  logic [RW-1:0]                 oldest_q, oldest_eff;
  logic [AVG_LOG2-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AVG_LOG2-1:0]           fill_cnt_q, fill_cnt_d;
  logic [RW-1:0]                 env;
  logic [INPUT_WIDTH-1:0]        out_q, out_d;
  logic                          valid_q, valid_d;
  logic                          use_oldest, fill_inc, sum_full;

  logic [RW-1:0] buf_mem [DEPTH];

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (RST) state_q <= FILL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == FILL && v2_q && fill_cnt_q == LAST_IDX)
      state_d = RUN;
  end

  // FSM: outputs
  always_comb begin
    use_oldest = (state_q == RUN);
    sum_full   = (state_q == RUN);
    fill_inc   = (state_q == FILL) && v2_q;
  end

  always_comb begin
    am_d   = AM_wave;
    v1_d   = 1'b1;
    am_neg = -am_q;
    if (am_q == {1'b1, {RW{1'b0}}})
      rect_d = '1;
    else if (am_q[INPUT_WIDTH-1])
      rect_d = am_neg[RW-1:0];
    else
      rect_d = am_q[RW-1:0];
    v2_d = v1_q;

    // During FILL the buffer holds stale data, so the departing sample counts as zero
    oldest_eff = use_oldest ? oldest_q : '0;
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    if (v2_q) begin
      sum_d    = sum_q + {{AVG_LOG2{1'b0}}, rect_q} - {{AVG_LOG2{1'b0}}, oldest_eff};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    fill_cnt_d = fill_inc ? fill_cnt_q + 1'b1 : fill_cnt_q;

    env     = sum_q[SUM_W-1:AVG_LOG2];
    valid_d = sum_full;
  end

`ifdef AM_DEMOD_DC_BLOCK_EN
  localparam int DC_W = RW + DC_SHIFT;

  logic [DC_W-1:0] dc_acc_q, dc_acc_d;
  logic [RW-1:0]   dc_sub;

  always_comb begin
    dc_sub   = dc_acc_q[DC_W-1:DC_SHIFT];
    dc_acc_d = dc_acc_q;
    if (state_q == RUN)
      dc_acc_d = dc_acc_q + {{DC_SHIFT{1'b0}}, env} - {{DC_SHIFT{1'b0}}, dc_sub};
    out_d = {1'b0, env} - {1'b0, dc_sub};
  end

  always_ff @(posedge clk_in) begin
    if (RST) dc_acc_q <= '0;
    else     dc_acc_q <= dc_acc_d;
  end
`else
  always_comb begin
    out_d = {1'b0, env};
  end
`endif

  always_ff @(posedge clk_in) begin
    if (RST) begin
      am_q       <= '0;
      v1_q       <= 1'b0;
      rect_q     <= '0;
      v2_q       <= 1'b0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      am_q       <= am_d;
      v1_q       <= v1_d;
      rect_q     <= rect_d;
      v2_q       <= v2_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  // Registered read one slot ahead of the write so the departing sample lines up with rect_q
  always_ff @(posedge clk_in) begin
    if (v2_q) buf_mem[wr_ptr_q] <= rect_q;
    oldest_q <= buf_mem[wr_ptr_d];
  end

  assign wave_out   = out_q;
  assign wave_valid = valid_q;

endmodule

// File: tb/tb_am_demodulate.sv
// Directed bench for am_demodulate: table of periodic patterns plus latency, mid-run reset
// and (with AM_DEMOD_DC_BLOCK_EN) DC decay sequences.
module tb_am_demodulate;

  logic               clk_in = 1'b0;
  logic               RST = 1'b1;
  logic signed [11:0] AM_wave = '0;
  logic signed [11:0] wave_out;
  logic               wave_valid;

  int checks = 0;
  int errors = 0;

  am_demodulate dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .AM_wave   (AM_wave),
    .wave_out  (wave_out),
    .wave_valid(wave_valid)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic signed [11:0] a;
    logic signed [11:0] b;
    int                 expected;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    AM_wave = 12'sd1234;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("reset wave_out", int'(wave_out), 0);
      check("reset wave_valid", int'(wave_valid), 0);
    end
    RST = 1'b0;
  endtask

  // Drives a two-phase pattern until the first valid; returns the sample index and output there.
  task automatic run_to_valid(input logic signed [11:0] a, input logic signed [11:0] b,
                              output int first_n, output int first_out);
    first_n = 0;
    first_out = 0;
    for (int n = 1; n <= 200 && first_n == 0; n++) begin
      AM_wave = (n % 2 == 1) ? a : b;
      tick();
      if (n == 1) begin
        check("post-release wave_out", int'(wave_out), 0);
        check("post-release wave_valid", int'(wave_valid), 0);
      end
      if (wave_valid) begin
        first_n = n;
        first_out = int'(wave_out);
      end
    end
  endtask

  initial begin
    int fn, fo, dropped, prev, nonmono;

    vecs[0] = '{a: 12'sd1000,  b: 12'sd1000,  expected: 1000};
    vecs[1] = '{a: -12'sd2048, b: -12'sd2048, expected: 2047};
    vecs[2] = '{a: 12'sd500,   b: -12'sd500,  expected: 500};
    vecs[3] = '{a: 12'sd2047,  b: 12'sd2047,  expected: 2047};
    vecs[4] = '{a: -12'sd1,    b: -12'sd1,    expected: 1};
    vecs[5] = '{a: 12'sd7,     b: -12'sd3,    expected: 5};
    vecs[6] = '{a: 12'sd100,   b: -12'sd1,    expected: 50};
    vecs[7] = '{a: 12'sd0,     b: 12'sd0,     expected: 0};

    for (int v = 0; v < 8; v++) begin
      $display("vector %0d: a=%0d b=%0d", v, vecs[v].a, vecs[v].b);
      do_reset(2);
      run_to_valid(vecs[v].a, vecs[v].b, fn, fo);
      check("first valid sample index", fn, 67);
      check("first valid wave_out", fo, vecs[v].expected);
      dropped = 0;
      for (int n = fn + 1; n <= 80; n++) begin
        AM_wave = (n % 2 == 1) ? vecs[v].a : vecs[v].b;
        tick();
        if (!wave_valid) dropped++;
      end
      check("wave_valid stays high", dropped, 0);
`ifndef AM_DEMOD_DC_BLOCK_EN
      check("steady wave_out", int'(wave_out), vecs[v].expected);
`endif
    end

    // Latency: a step captured at edge t shows on wave_out after edge t+3
    do_reset(1);
    run_to_valid(12'sd0, 12'sd0, fn, fo);
    for (int i = 0; i < 10; i++) begin
      AM_wave = 12'sd0;
      tick();
    end
    AM_wave = 12'sd640;
    tick();
    check("step +0 wave_out", int'(wave_out), 0);
    tick();
    check("step +1 wave_out", int'(wave_out), 0);
    tick();
    check("step +2 wave_out", int'(wave_out), 0);
    tick();
    check("step +3 wave_out", int'(wave_out), 10);
    tick();
    check("step +4 wave_out", int'(wave_out), 20);

    // Mid-run reset: no residue of the old window after refill
    do_reset(1);
    run_to_valid(12'sd1000, 12'sd1000, fn, fo);
    check("pre-reset first valid index", fn, 67);
    for (int i = 0; i < 100; i++) begin
      AM_wave = 12'sd1000;
      tick();
    end
    check("pre-reset wave_valid", int'(wave_valid), 1);
    RST = 1'b1;
    AM_wave = 12'sd300;
    tick();
    check("mid-run reset wave_valid", int'(wave_valid), 0);
    check("mid-run reset wave_out", int'(wave_out), 0);
    RST = 1'b0;
    run_to_valid(12'sd300, 12'sd300, fn, fo);
    check("refill first valid index", fn, 67);
    check("refill first valid wave_out", fo, 300);

`ifdef AM_DEMOD_DC_BLOCK_EN
    do_reset(1);
    run_to_valid(12'sd1000, 12'sd1000, fn, fo);
    check("dc first valid wave_out", fo, 1000);
    prev = fo;
    nonmono = 0;
    for (int i = 0; i < 16 * 256; i++) begin
      AM_wave = 12'sd1000;
      tick();
      if (int'(wave_out) > prev) nonmono++;
      prev = int'(wave_out);
    end
    check("dc monotonic decay violations", nonmono, 0);
    check("dc settled within 2", (prev <= 2 && prev >= -2) ? 1 : 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_demodulate.md
AM_DEMODULATE -- requirements
Module: am_demodulate

Interface
REQ-001 SHALL provide parameter INPUT_WIDTH, default 12: signed width of the AM input and of wave_out.
REQ-002 SHALL provide parameter AVG_LOG2, default 6: log2 of the boxcar window length (2^AVG_LOG2 samples).
REQ-003 SHALL provide parameter DC_SHIFT, default 8: leaky-integrator shift for DC removal (used only when AM_DEMOD_DC_BLOCK_EN is defined).
REQ-004 SHALL have port clk_in, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port AM_wave, input, INPUT_WIDTH: signed two's-complement modulated carrier, sampled on every clk_in edge.
REQ-007 SHALL have port wave_out, output, INPUT_WIDTH: demodulated envelope, signed two's-complement.
REQ-008 SHALL have port wave_valid, output, 1: high when wave_out reflects a full window.

Function
REQ-009 SHALL register AM_wave into am_r each cycle (stage 1) and carry a sample-valid bit alongside it.
REQ-010 SHALL full-wave rectify am_r into unsigned rect of INPUT_WIDTH-1 bits (stage 2): rect = |am_r|; am_r = -2^(INPUT_WIDTH-1) saturates to 2^(INPUT_WIDTH-1)-1.
REQ-011 SHALL hold 2^AVG_LOG2 rect samples in a circular buffer with a write pointer of AVG_LOG2 bits that wraps from 2^AVG_LOG2-1 to 0.
REQ-012 SHALL keep a running sum of INPUT_WIDTH-1+AVG_LOG2 bits updated as sum <= sum + rect - oldest (stage 3), with oldest the entry being overwritten; the sum SHALL never overflow.
REQ-013 SHALL form env = sum >> AVG_LOG2, truncated (stage 4), and drive wave_out from a register.
REQ-014 SHALL implement a two-state FSM: FILL and RUN. FILL: oldest is treated as 0 and a fill counter counts valid samples accumulated. On the 2^AVG_LOG2-th accumulation the FSM moves to RUN. RUN: oldest is the buffer entry, and the FSM stays in RUN until RST.
REQ-015 SHALL assert wave_valid exactly while the registered wave_out derives from a sum containing 2^AVG_LOG2 samples: first assertion 3 cycles after the 2^AVG_LOG2-th sample is captured into am_r, then continuously high.
REQ-016 SHALL have total latency of 4 register stages: a step on AM_wave at edge t first affects wave_out after edge t+3.
REQ-017 SHALL, without DC block, drive wave_out = env zero-extended to INPUT_WIDTH bits, range 0..2^(INPUT_WIDTH-1)-1.
REQ-018 SHALL never leave the buffer uninitialised in effect: stale buffer contents after reset SHALL NOT affect sum, because FILL masks oldest.

Reset
REQ-019 SHALL, on RST high at a clk_in edge, clear am_r, rect, sum, env, wave_out, the valid pipeline, the write pointer, the fill counter and the DC accumulator; wave_out = 0 and wave_valid = 0 from the next cycle.
REQ-020 SHALL NOT require the sample buffer to be cleared by reset.
REQ-021 SHALL, on RST asserted mid-RUN, drop wave_valid the next cycle, return the FSM to FILL, and require a full 2^AVG_LOG2 new samples before wave_valid reasserts.

Configuration
REQ-022 SHALL honour the macro AM_DEMOD_DC_BLOCK_EN.
- Defined: keep an accumulator dc_acc of INPUT_WIDTH-1+DC_SHIFT bits, updated only in RUN as dc_acc <= dc_acc + env - (dc_acc >> DC_SHIFT).
- Defined: wave_out = env - (dc_acc >> DC_SHIFT), signed, in range ±(2^(INPUT_WIDTH-1)-1) with no saturation needed.
- Defined: wave_out and wave_valid latency is unchanged.
- Not defined: no DC logic exists and REQ-017 applies.

Verification
REQ-023 SHALL cover reset: RST high 2 cycles with AM_wave = 1234 -> wave_out = 0 and wave_valid = 0 throughout and on the cycle after release.
REQ-024 SHALL cover a constant input: AM_wave = 1000 constant, defaults, macro undefined -> wave_valid first high 3 cycles after the 64th captured sample; wave_out = 1000 thereafter.
REQ-025 SHALL cover the negative boundary: AM_wave = -2048 constant -> wave_out = 2047 once valid.
REQ-026 SHALL cover an alternating input: AM_wave alternating +500/-500 -> wave_out = 500 steady once valid.
REQ-027 SHALL cover reset mid-run: after 100 valid cycles at 1000, pulse RST 1 cycle, then AM_wave = 300 -> wave_valid low the next cycle, high again after 64 samples + 3 cycles; wave_out = 300 with no residue of 1000.
REQ-028 SHALL cover DC removal: macro defined, AM_wave = 1000 constant -> first valid wave_out = 1000, decaying monotonically to within ±2 of 0 after 16×256 valid cycles.
